// File: rtl/vespa_int_pkg.sv
// vespa_int_pkg
// Definitions shared by the VeSPA interrupt controller and the CPU-side
// interrupt sequencer: the sequencer state encoding, the interrupt index
// width, and the default vector table placement.
package vespa_int_pkg;

    // Interrupt source index width (four sources).
    localparam int IRQ_W = 2;

    // Default vector table placement: vector n lives at base + n*stride.
    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0010;
    localparam int          DEF_VEC_STRIDE = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACK      = 3'd1,
        ST_VECTOR   = 3'd2,
        ST_IN_ISR   = 3'd3,
        ST_COMPLETE = 3'd4,
        ST_CHAIN    = 3'd5,
        ST_RESTORE  = 3'd6
    } seq_state_t;

endpackage

// File: rtl/int_vector_calc.sv
// int_vector_calc
// Combinational handler address: VEC_BASE + irq * VEC_STRIDE, evaluated in
// ADDR_W bits so an oversized table wraps instead of widening.
// Ports:
//   i_irq  - interrupt source index
//   o_addr - handler vector address
module int_vector_calc
    import vespa_int_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
    parameter int                VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic [IRQ_W-1:0]  i_irq,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] w_irq_ext;

    assign w_irq_ext = {{(ADDR_W-IRQ_W){1'b0}}, i_irq};
    assign o_addr    = VEC_BASE + (w_irq_ext * ADDR_W'(VEC_STRIDE));

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
// CPU-side responder for the VeSPA interrupt controller. Accepts a request at
// an instruction boundary, acknowledges it, vectors the core to the handler,
// and on RETI either restores the saved PC/condition codes or tail-chains
// straight into the next pending handler without restoring context.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-low reset
//   int_req, int_number - request and source index from the controller
//   ie                  - core global interrupt enable
//   instr_boundary      - core retiring an instruction; pc_next valid
//   pc_next, cc_in      - resume address and live condition codes
//   reti_exec           - core executing RETI (one-cycle pulse)
//   int_ack_attended    - acceptance pulse to the controller
//   int_ack_complete    - completion pulse to the controller
//   core_hold           - freeze fetch/issue
//   pc_load/_value      - PC load strobe and address (vector or resume)
//   cc_load/cc_restore  - status load strobe and saved condition codes
//   in_isr, active_irq  - handler context flag and source being serviced
//   spurious_reti       - sticky flag: RETI seen outside a handler
module interrupt_sequencer
    import vespa_int_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                CC_W       = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
    parameter int                VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic [IRQ_W-1:0]  int_number,
    input  logic              ie,
    input  logic              instr_boundary,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic [CC_W-1:0]   cc_in,
    input  logic              reti_exec,
    output logic              int_ack_attended,
    output logic              int_ack_complete,
    output logic              core_hold,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_value,
    output logic              cc_load,
    output logic [CC_W-1:0]   cc_restore,
    output logic              in_isr,
    output logic [IRQ_W-1:0]  active_irq,
    output logic              spurious_reti
);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_saved_pc;
    logic [CC_W-1:0]   r_saved_cc;
    logic [IRQ_W-1:0]  r_active_irq;
    logic              r_ack_att;
    logic              r_ack_cmp;
    logic              r_hold;
    logic              r_pc_load;
    logic [ADDR_W-1:0] r_pc_value;
    logic              r_cc_load;
    logic [CC_W-1:0]   r_cc_restore;
    logic              r_in_isr;
    logic              r_spurious;
    logic [ADDR_W-1:0] w_vec_addr;

    int_vector_calc #(
        .ADDR_W     (ADDR_W),
        .VEC_BASE   (VEC_BASE),
        .VEC_STRIDE (VEC_STRIDE)
    ) u_vec (
        .i_irq  (r_active_irq),
        .o_addr (w_vec_addr)
    );

    // Outputs are registered: every transition writes the output values that
    // belong to the state being entered, so they line up with r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_saved_pc   <= '0;
            r_saved_cc   <= '0;
            r_active_irq <= '0;
            r_ack_att    <= 1'b0;
            r_ack_cmp    <= 1'b0;
            r_hold       <= 1'b0;
            r_pc_load    <= 1'b0;
            r_pc_value   <= '0;
            r_cc_load    <= 1'b0;
            r_cc_restore <= '0;
            r_in_isr     <= 1'b0;
            r_spurious   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless the entered state re-asserts them.
            r_ack_att <= 1'b0;
            r_ack_cmp <= 1'b0;
            r_hold    <= 1'b0;
            r_pc_load <= 1'b0;
            r_cc_load <= 1'b0;

            // RETI only means something inside a handler; elsewhere it is
            // recorded as an error and otherwise ignored.
            if (reti_exec && (r_state != ST_IN_ISR)) begin
                r_spurious <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_in_isr <= 1'b0;
                    if (int_req && ie && instr_boundary) begin
                        r_state      <= ST_ACK;
                        r_saved_pc   <= pc_next;
                        r_saved_cc   <= cc_in;
                        r_active_irq <= int_number;
                        r_ack_att    <= 1'b1;
                        r_hold       <= 1'b1;
                        r_in_isr     <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_state    <= ST_VECTOR;
                    r_pc_load  <= 1'b1;
                    r_pc_value <= w_vec_addr;
                    r_hold     <= 1'b1;
                    r_in_isr   <= 1'b1;
                end
                ST_VECTOR: begin
                    r_state  <= ST_IN_ISR;
                    r_in_isr <= 1'b1;
                end
                ST_IN_ISR: begin
                    // No preemption: int_req is not looked at while handling.
                    r_in_isr <= 1'b1;
                    if (reti_exec) begin
                        r_state   <= ST_COMPLETE;
                        r_ack_cmp <= 1'b1;
                        r_hold    <= 1'b1;
                    end
                end
                ST_COMPLETE: begin
                    r_state  <= ST_CHAIN;
                    r_hold   <= 1'b1;
                    r_in_isr <= 1'b1;
                end
                ST_CHAIN: begin
                    // The controller has re-arbitrated by now. A pending request
                    // chains directly, keeping the original resume context and
                    // ignoring ie (still inside the interrupt epoch).
                    if (int_req) begin
                        r_state      <= ST_ACK;
                        r_active_irq <= int_number;
                        r_ack_att    <= 1'b1;
                        r_hold       <= 1'b1;
                        r_in_isr     <= 1'b1;
                    end else begin
                        r_state      <= ST_RESTORE;
                        r_pc_load    <= 1'b1;
                        r_pc_value   <= r_saved_pc;
                        r_cc_load    <= 1'b1;
                        r_cc_restore <= r_saved_cc;
                        r_in_isr     <= 1'b0;
                    end
                end
                ST_RESTORE: begin
                    r_state  <= ST_IDLE;
                    r_in_isr <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_in_isr <= 1'b0;
                end
            endcase
        end
    end

    assign int_ack_attended = r_ack_att;
    assign int_ack_complete = r_ack_cmp;
    assign core_hold        = r_hold;
    assign pc_load          = r_pc_load;
    assign pc_load_value    = r_pc_value;
    assign cc_load          = r_cc_load;
    assign cc_restore       = r_cc_restore;
    assign in_isr           = r_in_isr;
    assign active_irq       = r_active_irq;
    assign spurious_reti    = r_spurious;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer
// Directed steps plus randomized handler/tail-chain sessions. Expected values
// come from a plain reference model: vector = 0x10 + 4*irq, and a session
// always resumes at the PC/CC captured when it was first entered.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        int_req = 1'b0;
    logic [1:0]  int_number = '0;
    logic        ie = 1'b0;
    logic        instr_boundary = 1'b0;
    logic [31:0] pc_next = '0;
    logic [3:0]  cc_in = '0;
    logic        reti_exec = 1'b0;
    logic        int_ack_attended;
    logic        int_ack_complete;
    logic        core_hold;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        cc_load;
    logic [3:0]  cc_restore;
    logic        in_isr;
    logic [1:0]  active_irq;
    logic        spurious_reti;

    int total = 0;
    int bad   = 0;

    interrupt_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .int_req          (int_req),
        .int_number       (int_number),
        .ie               (ie),
        .instr_boundary   (instr_boundary),
        .pc_next          (pc_next),
        .cc_in            (cc_in),
        .reti_exec        (reti_exec),
        .int_ack_attended (int_ack_attended),
        .int_ack_complete (int_ack_complete),
        .core_hold        (core_hold),
        .pc_load          (pc_load),
        .pc_load_value    (pc_load_value),
        .cc_load          (cc_load),
        .cc_restore       (cc_restore),
        .in_isr           (in_isr),
        .active_irq       (active_irq),
        .spurious_reti    (spurious_reti)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] vec_of(input int irq);
        return 32'(32'h10 + irq * 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_att"},  32'(int_ack_attended), 0);
        chk({tag, "_cmp"},  32'(int_ack_complete), 0);
        chk({tag, "_hold"}, 32'(core_hold), 0);
        chk({tag, "_pcl"},  32'(pc_load), 0);
        chk({tag, "_pcv"},  pc_load_value, 0);
        chk({tag, "_ccl"},  32'(cc_load), 0);
        chk({tag, "_ccr"},  32'(cc_restore), 0);
        chk({tag, "_isr"},  32'(in_isr), 0);
        chk({tag, "_irq"},  32'(active_irq), 0);
        chk({tag, "_spur"}, 32'(spurious_reti), 0);
    endtask

    // Qualifying boundary from IDLE through to running in the handler.
    task automatic enter(input logic [1:0] irq, input logic [31:0] pc, input logic [3:0] cc);
        int_req = 1'b1; int_number = irq; ie = 1'b1;
        instr_boundary = 1'b1; pc_next = pc; cc_in = cc;
        tick();
        int_req = 1'b0; instr_boundary = 1'b0;
        pc_next = $urandom; cc_in = ~cc; int_number = irq + 2'd1;
        chk("ack_att",   32'(int_ack_attended), 1);
        chk("ack_excl",  32'(int_ack_complete), 0);
        chk("ack_hold",  32'(core_hold), 1);
        chk("ack_isr",   32'(in_isr), 1);
        chk("ack_irq",   32'(active_irq), 32'(irq));
        chk("ack_nopcl", 32'(pc_load), 0);
        tick();
        chk("vec_load",  32'(pc_load), 1);
        chk("vec_addr",  pc_load_value, vec_of(irq));
        chk("vec_att1",  32'(int_ack_attended), 0);
        chk("vec_hold",  32'(core_hold), 1);
        tick();
        chk("run_isr",   32'(in_isr), 1);
        chk("run_hold",  32'(core_hold), 0);
        chk("run_pcl",   32'(pc_load), 0);
    endtask

    // RETI then COMPLETE; leaves the bench sitting in the CHAIN cycle.
    task automatic reti_to_chain();
        reti_exec = 1'b1;
        tick();
        reti_exec = 1'b0;
        chk("cmp_pulse", 32'(int_ack_complete), 1);
        chk("cmp_excl",  32'(int_ack_attended), 0);
        chk("cmp_hold",  32'(core_hold), 1);
        chk("cmp_isr",   32'(in_isr), 1);
        tick();
        chk("chn_cmp1",  32'(int_ack_complete), 0);
        chk("chn_hold",  32'(core_hold), 1);
        chk("chn_isr",   32'(in_isr), 1);
    endtask

    task automatic reti_restore(input logic [31:0] pc, input logic [3:0] cc);
        reti_to_chain();
        int_req = 1'b0;
        tick();
        chk("rst_pcl",   32'(pc_load), 1);
        chk("rst_pcv",   pc_load_value, pc);
        chk("rst_ccl",   32'(cc_load), 1);
        chk("rst_ccv",   32'(cc_restore), 32'(cc));
        chk("rst_isr",   32'(in_isr), 0);
        chk("rst_att",   32'(int_ack_attended), 0);
        tick();
        chk("idle_pcl",  32'(pc_load), 0);
        chk("idle_ccl",  32'(cc_load), 0);
        chk("idle_isr",  32'(in_isr), 0);
    endtask

    task automatic reti_chain(input logic [1:0] irq);
        reti_to_chain();
        int_req = 1'b1; int_number = irq; ie = 1'b0;
        tick();
        int_req = 1'b0; ie = 1'b1;
        chk("tc_att",    32'(int_ack_attended), 1);
        chk("tc_irq",    32'(active_irq), 32'(irq));
        chk("tc_cmp",    32'(int_ack_complete), 0);
        chk("tc_nopcl",  32'(pc_load), 0);
        tick();
        chk("tc_vload",  32'(pc_load), 1);
        chk("tc_vaddr",  pc_load_value, vec_of(irq));
        chk("tc_nocc",   32'(cc_load), 0);
        tick();
        chk("tc_run",    32'(in_isr), 1);
    endtask

    initial begin
        logic [1:0]  r_irq;
        logic [31:0] r_pc;
        logic [3:0]  r_cc;
        int          n_chain;

        // Reset state.
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Basic handler: irq 2 at 0x100.
        enter(2'd2, 32'h100, 4'hA);
        repeat (3) tick();
        chk("isr_stay", 32'(in_isr), 1);
        reti_restore(32'h100, 4'hA);

        // Tail-chain: irq 1 then irq 3, resume at original context.
        enter(2'd1, 32'h2000, 4'h5);
        reti_chain(2'd3);
        reti_restore(32'h2000, 4'h5);

        // Requests blocked by ie=0 across ten boundaries.
        int_req = 1'b1; int_number = 2'd0; ie = 1'b0; instr_boundary = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc_next = $urandom;
            tick();
            chk("ie_block", 32'(int_ack_attended), 0);
            chk("ie_idle",  32'(in_isr), 0);
        end
        // Request without a boundary also waits.
        ie = 1'b1; instr_boundary = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nobnd_wait", 32'(int_ack_attended), 0);
        end
        enter(2'd0, 32'h300, 4'h3);
        reti_restore(32'h300, 4'h3);

        // Randomized sessions with random chain depth.
        for (int s = 0; s < 8; s++) begin
            r_irq   = 2'($urandom_range(0, 3));
            r_pc    = $urandom;
            r_cc    = 4'($urandom_range(0, 15));
            n_chain = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) tick();
            enter(r_irq, r_pc, r_cc);
            repeat ($urandom_range(0, 4)) tick();
            for (int c = 0; c < n_chain; c++) begin
                reti_chain(2'($urandom_range(0, 3)));
                repeat ($urandom_range(0, 3)) tick();
            end
            reti_restore(r_pc, r_cc);
        end
        chk("no_spur_yet", 32'(spurious_reti), 0);

        // Spurious RETI in IDLE.
        reti_exec = 1'b1;
        tick();
        reti_exec = 1'b0;
        chk("spur_set",  32'(spurious_reti), 1);
        chk("spur_att",  32'(int_ack_attended), 0);
        chk("spur_cmp",  32'(int_ack_complete), 0);
        chk("spur_isr",  32'(in_isr), 0);
        tick();
        chk("spur_stick", 32'(spurious_reti), 1);
        enter(2'd3, 32'h440, 4'hF);
        reti_restore(32'h440, 4'hF);
        chk("spur_keep", 32'(spurious_reti), 1);

        // Asynchronous reset while inside a handler.
        enter(2'd2, 32'h5550, 4'h9);
        #3 rst = 1'b0;
        #1;
        check_all_zero("async");
        tick();
        chk("rst_nocmp", 32'(int_ack_complete), 0);
        #2 rst = 1'b1;
        tick();
        enter(2'd1, 32'h6660, 4'h6);
        reti_restore(32'h6660, 4'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
